edge_burst_gen: RTL and testbench

Generates a counted burst of fixed-width pulses, one per rising edge of a divided tick signal. The block sits directly downstream of the frequency divider: `tick_in` is the divider's `out`, which is synchronous to `clk`. Firmware arms a burst with a single-cycle trigger, and the block emits `burst_len` pulses, each aligned to a tick edge. It flags ticks that arrive while a pulse is still active, and signals completion with a one-cycle `done`.

---
 rtl/edge_burst_gen.sv | 152 +++++++++++++++
 tb/tb_edge_burst_gen.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_burst_gen.sv
// Counted burst of fixed-width pulses, one per rising edge of a clk-synchronous tick.
// Latency: trigger -> busy next cycle; tick edge -> pulse_out next cycle for W cycles.
// Backpressure: none; tick edges arriving mid-pulse are dropped and flagged in overrun.
//
// Ports:
//   clk, reset (async, active-low)
//   tick_in            divided tick, synchronous to clk
//   trigger / abort    one-cycle start / stop requests (abort wins)
//   burst_len [LW]     pulses per burst, latched on an accepted trigger
//   pulse_width [CW]   pulse high time in clk cycles (0 treated as 1), latched on trigger
//   pulse_out, busy, done, overrun, pulse_count [LW]   registered status outputs
module edge_burst_gen #(
   parameter int CW = 32,
   parameter int LW = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          tick_in,
   input  logic          trigger,
   input  logic          abort,
   input  logic [LW-1:0] burst_len,
   input  logic [CW-1:0] pulse_width,
   output logic          pulse_out,
   output logic          busy,
   output logic          done,
   output logic          overrun,
   output logic [LW-1:0] pulse_count
);

   localparam logic [CW-1:0] W_ONE = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [LW-1:0] L_ONE = {{(LW-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      PULSE = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic          tick_d;
   logic          tick_edge;
   logic [LW-1:0] len_q;
   logic [CW-1:0] w_q;
   logic [CW-1:0] wcnt;
   logic          last_cyc;
   logic          accept;     // trigger taken in IDLE: latch shadows, clear status
   logic          start;      // edge taken in WAIT: begin a pulse
   logic          finish;     // burst complete (or zero-length): done next cycle
   logic          drop;       // edge seen while a pulse is still high
   logic          pulse_nxt;
   logic          busy_nxt;

   // tick_d resets high so a tick already high at reset release is not an edge.
   assign tick_edge = tick_in & ~tick_d;
   assign last_cyc  = (wcnt == W_ONE);

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; abort overrides everything, including the edge bookkeeping.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      start     = 1'b0;
      finish    = 1'b0;
      drop      = 1'b0;
      if (abort) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (trigger) begin
                  accept = 1'b1;
                  if (burst_len == '0) begin
                     finish = 1'b1;
                  end else begin
                     state_nxt = WAIT;
                  end
               end
            end
            WAIT: begin
               if (tick_edge) begin
                  start     = 1'b1;
                  state_nxt = PULSE;
               end
            end
            PULSE: begin
               drop = tick_edge;
               if (last_cyc) begin
                  // pulse_count already includes the pulse now ending
                  if (pulse_count == len_q) begin
                     state_nxt = IDLE;
                     finish    = 1'b1;
                  end else begin
                     state_nxt = WAIT;
                  end
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Output decode of the next state so the outputs can be registered.
   always_comb begin
      pulse_nxt = (state_nxt == PULSE);
      busy_nxt  = (state_nxt != IDLE);
   end

   // Registered outputs and datapath
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tick_d      <= 1'b1;
         pulse_out   <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         overrun     <= 1'b0;
         pulse_count <= '0;
         len_q       <= '0;
         w_q         <= W_ONE;
         wcnt        <= W_ONE;
      end else begin
         tick_d    <= tick_in;
         pulse_out <= pulse_nxt;
         busy      <= busy_nxt;
         done      <= finish;
         if (accept) begin
            len_q       <= burst_len;
            w_q         <= (pulse_width == '0) ? W_ONE : pulse_width;
            pulse_count <= '0;
            overrun     <= 1'b0;
         end
         if (start) begin
            wcnt        <= w_q;
            pulse_count <= pulse_count + L_ONE;
         end else if (state == PULSE) begin
            wcnt <= wcnt - W_ONE;
         end
         if (drop) begin
            overrun <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_edge_burst_gen.sv
// Bench for edge_burst_gen: per-cycle traces compared against an event-level model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_edge_burst_gen;

   localparam int CW   = 6;
   localparam int LW   = 8;
   localparam int NMAX = 256;

   logic          clk = 1'b0;
   logic          reset;
   logic          tick_in;
   logic          trigger;
   logic          abort;
   logic [LW-1:0] burst_len;
   logic [CW-1:0] pulse_width;
   logic          pulse_out;
   logic          busy;
   logic          done;
   logic          overrun;
   logic [LW-1:0] pulse_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   edge_burst_gen #(.CW(CW), .LW(LW)) dut (
      .clk         (clk),
      .reset       (reset),
      .tick_in     (tick_in),
      .trigger     (trigger),
      .abort       (abort),
      .burst_len   (burst_len),
      .pulse_width (pulse_width),
      .pulse_out   (pulse_out),
      .busy        (busy),
      .done        (done),
      .overrun     (overrun),
      .pulse_count (pulse_count)
   );

   // Trace word layout: {pulse_out, busy, done, overrun, pulse_count}
   localparam int BP = LW + 3;
   localparam int BB = LW + 2;
   localparam int BD = LW + 1;
   localparam int BO = LW;
   wire logic [LW+3:0] obs_now = {pulse_out, busy, done, overrun, pulse_count};

   // Per-cycle stimulus (index = cycle in which the input is sampled)
   bit            tk  [NMAX];
   bit            trg [NMAX];
   bit            ab  [NMAX];
   logic [LW-1:0] blen[NMAX];
   logic [CW-1:0] pw  [NMAX];

   // Model results (index = cycle in which the output is visible)
   bit            mp[NMAX+1];
   bit            mb[NMAX+1];
   bit            md[NMAX+1];
   bit            mo[NMAX+1];
   int            mc[NMAX+1];
   logic [LW+3:0] exp_v[NMAX+1];
   logic [LW+3:0] obs_v[NMAX+1];

   bit last_tick;  // tick value seen in the cycle before a scenario starts
   int m_cnt;      // status carried over from the previous burst
   bit m_ovr;

   function automatic bit is_edge(int e);
      bit prev;
      prev = (e == 0) ? last_tick : tk[e-1];
      return tk[e] && !prev;
   endfunction

   task automatic clear_stim(int n, int len, int w, bit guard);
      for (int k = 0; k < NMAX; k++) begin
         tk[k]   = 1'b0;
         trg[k]  = 1'b0;
         ab[k]   = 1'b0;
         blen[k] = LW'(len);
         pw[k]   = CW'(w);
      end
      // a trailing abort guarantees the next scenario starts idle
      if (guard) ab[n-1] = 1'b1;
   endtask

   task automatic gen_div(int n, int period, int high, int phase);
      for (int k = 0; k < n; k++) tk[k] = (((k + phase) % period) >= (period - high));
   endtask

   // Event-level model: walk the tick edges after the trigger, accept one
   // whenever the previous pulse has fully ended, and lay out windows in time.
   function automatic void build_model(int n);
      int t, a, len, w, cnt, ready, fin, last;
      t = -1;
      a = NMAX + 10;
      for (int k = 0; k < n; k++) begin
         if (trg[k] && t < 0) t = k;
         if (ab[k] && a > NMAX) a = k;
      end
      for (int k = 0; k <= n; k++) begin
         mp[k] = 0; mb[k] = 0; md[k] = 0; mo[k] = m_ovr; mc[k] = m_cnt;
      end
      if (t >= 0 && a > t) begin
         for (int k = t + 1; k <= n; k++) begin
            mo[k] = 0; mc[k] = 0;
         end
         len = int'(blen[t]);
         w   = (pw[t] == '0) ? 1 : int'(pw[t]);
         if (len == 0) begin
            md[t+1] = 1;
         end else begin
            cnt = 0; ready = t + 1; fin = -1;
            for (int e = t + 1; e < n && e < a; e++) begin
               if (is_edge(e)) begin
                  if (cnt < len && e >= ready) begin
                     cnt++;
                     for (int k = e + 1; k <= e + w && k <= n && k <= a; k++) mp[k] = 1;
                     for (int k = e + 1; k <= n; k++) mc[k] = cnt;
                     ready = e + w + 1;
                     if (cnt == len) fin = ready;
                  end else if (cnt > 0 && e < ready) begin
                     for (int k = e + 1; k <= n; k++) mo[k] = 1;
                  end
               end
            end
            if (fin >= 0 && fin <= a && fin <= n) md[fin] = 1;
            last = (fin >= 0) ? fin - 1 : n;
            if (a < last) last = a;
            for (int k = t + 1; k <= last && k <= n; k++) mb[k] = 1;
         end
      end
      for (int k = 0; k <= n; k++) exp_v[k] = {mp[k], mb[k], md[k], mo[k], LW'(mc[k])};
   endfunction

   task automatic run_stim(int n);
      obs_v[0] = obs_now;
      for (int k = 0; k < n; k++) begin
         tick_in     = tk[k];
         trigger     = trg[k];
         abort       = ab[k];
         burst_len   = blen[k];
         pulse_width = pw[k];
         @(posedge clk);
         #1;
         obs_v[k+1] = obs_now;
      end
      trigger   = 1'b0;
      abort     = 1'b0;
      last_tick = tk[n-1];
      m_cnt     = mc[n];
      m_ovr     = mo[n];
   endtask

   function automatic int count_bit(int n, int b);
      int s = 0;
      for (int k = 0; k <= n; k++) s += int'(obs_v[k][b]);
      return s;
   endfunction

   task automatic test_reset();
      checks++; if (pulse_out !== 1'b0) begin errors++; $display("FAIL reset pulse_out got %b exp 0", pulse_out); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got %b exp 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset done got %b exp 0", done); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset overrun got %b exp 0", overrun); end
      checks++; if (pulse_count !== '0) begin errors++; $display("FAIL reset pulse_count got %0d exp 0", pulse_count); end
   endtask

   // tick held high through reset release; width 0 behaves as a 1-cycle pulse
   task automatic test_tick_high_at_reset();
      int n = 16;
      clear_stim(n, 1, 0, 1'b1);
      for (int k = 0; k < n; k++) tk[k] = (k < 6) ? 1'b1 : (((k - 6) % 4) >= 2);
      trg[1] = 1'b1;
      build_model(n);
      run_stim(n);
      for (int k = 0; k <= n; k++) begin
         checks++;
         if (obs_v[k] !== exp_v[k]) begin errors++; $display("FAIL tickhigh trace cyc %0d got %h exp %h", k, obs_v[k], exp_v[k]); end
      end
      checks++; if (obs_v[9][BP] !== 1'b1) begin errors++; $display("FAIL tickhigh first_pulse got %b exp 1", obs_v[9][BP]); end
      checks++; if (count_bit(n, BP) != 1) begin errors++; $display("FAIL tickhigh pulse_cycles got %0d exp 1", count_bit(n, BP)); end
   endtask

   task automatic test_basic();
      int n = 40;
      clear_stim(n, 3, 2, 1'b1);
      gen_div(n, 4, 2, int'($urandom_range(0, 3)));
      trg[2] = 1'b1;
      build_model(n);
      run_stim(n);
      for (int k = 0; k <= n; k++) begin
         checks++;
         if (obs_v[k] !== exp_v[k]) begin errors++; $display("FAIL basic trace cyc %0d got %h exp %h", k, obs_v[k], exp_v[k]); end
      end
      checks++; if (count_bit(n, BP) != 6) begin errors++; $display("FAIL basic pulse_cycles got %0d exp 6", count_bit(n, BP)); end
      checks++; if (count_bit(n, BD) != 1) begin errors++; $display("FAIL basic done_count got %0d exp 1", count_bit(n, BD)); end
      checks++; if (obs_v[n][LW-1:0] !== LW'(3)) begin errors++; $display("FAIL basic pulse_count got %0d exp 3", obs_v[n][LW-1:0]); end
      checks++; if (obs_v[n][BO] !== 1'b0) begin errors++; $display("FAIL basic overrun got %b exp 0", obs_v[n][BO]); end
   endtask

   task automatic test_overrun();
      int n = 48;
      clear_stim(n, 3, 5, 1'b1);
      gen_div(n, 4, 2, int'($urandom_range(0, 3)));
      trg[1] = 1'b1;
      build_model(n);
      run_stim(n);
      for (int k = 0; k <= n; k++) begin
         checks++;
         if (obs_v[k] !== exp_v[k]) begin errors++; $display("FAIL overrun trace cyc %0d got %h exp %h", k, obs_v[k], exp_v[k]); end
      end
      checks++; if (obs_v[n][BO] !== 1'b1) begin errors++; $display("FAIL overrun flag got %b exp 1", obs_v[n][BO]); end
      checks++; if (count_bit(n, BP) != 15) begin errors++; $display("FAIL overrun pulse_cycles got %0d exp 15", count_bit(n, BP)); end
      checks++; if (count_bit(n, BD) != 1) begin errors++; $display("FAIL overrun done_count got %0d exp 1", count_bit(n, BD)); end
   endtask

   task automatic test_zero_len();
      int n = 10;
      clear_stim(n, 0, 3, 1'b1);
      gen_div(n, 4, 2, 0);
      trg[3] = 1'b1;
      build_model(n);
      run_stim(n);
      for (int k = 0; k <= n; k++) begin
         checks++;
         if (obs_v[k] !== exp_v[k]) begin errors++; $display("FAIL zerolen trace cyc %0d got %h exp %h", k, obs_v[k], exp_v[k]); end
      end
      checks++; if (obs_v[4][BD] !== 1'b1) begin errors++; $display("FAIL zerolen done_t1 got %b exp 1", obs_v[4][BD]); end
      checks++; if (count_bit(n, BB) != 0) begin errors++; $display("FAIL zerolen busy_cycles got %0d exp 0", count_bit(n, BB)); end
      checks++; if (count_bit(n, BP) != 0) begin errors++; $display("FAIL zerolen pulse_cycles got %0d exp 0", count_bit(n, BP)); end
   endtask

   task automatic test_abort();
      int n = 40;
      int k2 = -1;
      int rises = 0;
      clear_stim(n, 4, 2, 1'b1);
      gen_div(n, 4, 2, int'($urandom_range(0, 3)));
      trg[1] = 1'b1;
      build_model(n);
      for (int k = 1; k <= n; k++) begin
         if (exp_v[k][BP] && !exp_v[k-1][BP]) begin
            rises++;
            if (rises == 2) k2 = k;
         end
      end
      if (k2 < 0) k2 = 10;
      ab[k2] = 1'b1;
      build_model(n);
      run_stim(n);
      for (int k = 0; k <= n; k++) begin
         checks++;
         if (obs_v[k] !== exp_v[k]) begin errors++; $display("FAIL abort trace cyc %0d got %h exp %h", k, obs_v[k], exp_v[k]); end
      end
      checks++; if (obs_v[k2+1][BP] !== 1'b0) begin errors++; $display("FAIL abort pulse_after got %b exp 0", obs_v[k2+1][BP]); end
      checks++; if (obs_v[k2+1][BB] !== 1'b0) begin errors++; $display("FAIL abort busy_after got %b exp 0", obs_v[k2+1][BB]); end
      checks++; if (count_bit(n, BD) != 0) begin errors++; $display("FAIL abort done_count got %0d exp 0", count_bit(n, BD)); end
      checks++; if (obs_v[n][LW-1:0] !== LW'(2)) begin errors++; $display("FAIL abort pulse_count got %0d exp 2", obs_v[n][LW-1:0]); end
   endtask

   task automatic test_ignored();
      int n = 40;
      clear_stim(n, 3, 2, 1'b1);
      gen_div(n, 4, 2, 0);
      trg[1]  = 1'b1;
      trg[12] = 1'b1;
      for (int k = 8; k < n; k++) begin
         blen[k] = LW'(7);
         pw[k]   = CW'(9);
      end
      build_model(n);
      run_stim(n);
      for (int k = 0; k <= n; k++) begin
         checks++;
         if (obs_v[k] !== exp_v[k]) begin errors++; $display("FAIL ignored trace cyc %0d got %h exp %h", k, obs_v[k], exp_v[k]); end
      end
      checks++; if (obs_v[n][LW-1:0] !== LW'(3)) begin errors++; $display("FAIL ignored pulse_count got %0d exp 3", obs_v[n][LW-1:0]); end
      checks++; if (count_bit(n, BD) != 1) begin errors++; $display("FAIL ignored done_count got %0d exp 1", count_bit(n, BD)); end
   endtask

   // edges W+1 apart are all accepted; edges W apart hit the last pulse cycle
   task automatic test_spacing();
      int n = 40;
      for (int per = 4; per >= 3; per--) begin
         clear_stim(n, 3, 3, 1'b1);
         gen_div(n, per, 1, 0);
         trg[0] = 1'b1;
         build_model(n);
         run_stim(n);
         for (int k = 0; k <= n; k++) begin
            checks++;
            if (obs_v[k] !== exp_v[k]) begin errors++; $display("FAIL spacing%0d trace cyc %0d got %h exp %h", per, k, obs_v[k], exp_v[k]); end
         end
         checks++;
         if (obs_v[n][BO] !== ((per == 3) ? 1'b1 : 1'b0)) begin
            errors++; $display("FAIL spacing%0d overrun got %b exp %b", per, obs_v[n][BO], per == 3);
         end
      end
   endtask

   task automatic test_max_width();
      int n = 150;
      clear_stim(n, 2, (1 << CW) - 1, 1'b1);
      for (int k = 0; k < n; k++) tk[k] = ((k % 70) == 5);
      trg[1] = 1'b1;
      build_model(n);
      run_stim(n);
      for (int k = 0; k <= n; k++) begin
         checks++;
         if (obs_v[k] !== exp_v[k]) begin errors++; $display("FAIL maxw trace cyc %0d got %h exp %h", k, obs_v[k], exp_v[k]); end
      end
      checks++; if (count_bit(n, BP) != 126) begin errors++; $display("FAIL maxw pulse_cycles got %0d exp 126", count_bit(n, BP)); end
   endtask

   task automatic test_random();
      int n = 120;
      int t;
      bit cur;
      for (int it = 0; it < 20; it++) begin
         clear_stim(n, int'($urandom_range(0, 4)), int'($urandom_range(0, 6)), 1'b1);
         t   = int'($urandom_range(0, 5));
         cur = last_tick;
         for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 2) == 0) cur = ~cur;
            tk[k] = cur;
            if (k > t) begin
               blen[k] = LW'($urandom);
               pw[k]   = CW'($urandom);
            end
         end
         trg[t] = 1'b1;
         if ($urandom_range(0, 2) == 0) ab[$urandom_range(6, 100)] = 1'b1;
         build_model(n);
         run_stim(n);
         for (int k = 0; k <= n; k++) begin
            checks++;
            if (obs_v[k] !== exp_v[k]) begin errors++; $display("FAIL random%0d trace cyc %0d got %h exp %h", it, k, obs_v[k], exp_v[k]); end
         end
      end
   endtask

   task automatic test_async_reset();
      int n = 15;
      clear_stim(n, 3, 4, 1'b0);
      gen_div(n, 8, 4, 0);
      trg[1] = 1'b1;
      build_model(n);
      run_stim(n);
      for (int k = 0; k <= n; k++) begin
         checks++;
         if (obs_v[k] !== exp_v[k]) begin errors++; $display("FAIL asyncrst trace cyc %0d got %h exp %h", k, obs_v[k], exp_v[k]); end
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if (obs_now !== '0) begin errors++; $display("FAIL asyncrst outputs got %h exp 0", obs_now); end
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         checks++;
         if (done !== 1'b0) begin errors++; $display("FAIL asyncrst done got %b exp 0", done); end
      end
      #2 reset = 1'b1;
      last_tick = 1'b1;
      m_cnt     = 0;
      m_ovr     = 1'b0;
   endtask

   initial begin
      reset       = 1'b0;
      tick_in     = 1'b1;
      trigger     = 1'b0;
      abort       = 1'b0;
      burst_len   = '0;
      pulse_width = '0;
      last_tick   = 1'b1;
      m_cnt       = 0;
      m_ovr       = 1'b0;
      repeat (3) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      test_reset();
      test_tick_high_at_reset();
      test_basic();
      test_overrun();
      test_zero_len();
      test_abort();
      test_ignored();
      test_spacing();
      test_max_width();
      test_random();
      test_async_reset();
      test_basic();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
